// File: rtl/tamagotchi_input_cond.sv
// -----------------------------------------------------------------------------
// tamagotchi_input_cond
//
// Input conditioning for the Tamagotchi front panel and sensors. Each raw input
// passes through a 2-flop synchronizer and then a tick-based debouncer. A
// single free-running prescaler supplies the 1 ms tick to every channel. The
// reset and test buttons can also be gated by a long-press qualifier.
//
// Optional feature macro: INPUT_COND_HOLD_EN
//   defined     : btn_reset / btn_test go through the long-press FSM
//                 (IDLE -> HOLD -> ACTIVE) and must be held for HOLD_MS.
//   not defined : btn_reset / btn_test are the plain debounced levels. HOLD_MS
//                 is ignored and no hold counters are built.
//   In both builds an asserted btn_reset forces btn_test to its released level.
//
// Parameters
//   CLK_HZ       clock frequency in Hz. Must be a multiple of 1000.
//   DEBOUNCE_MS  consecutive 1 ms ticks needed to accept a level change (1..255).
//   HOLD_MS      long-press time for btn_reset / btn_test in ms (1..65535).
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous reset, active low
//   btn_salud_raw  in   raw pushbutton, active low, asynchronous to clk
//   btn_ali_raw    in   raw pushbutton, active low, asynchronous to clk
//   btn_reset_raw  in   raw pushbutton, active low, asynchronous to clk
//   btn_test_raw   in   raw pushbutton, active low, asynchronous to clk
//   gyro_raw       in   raw tilt sensor, active low
//   ult_raw        in   raw ultrasonic presence flag, active high
//   btn_salud      out  debounced level, active low
//   btn_ali        out  debounced level, active low
//   btn_reset      out  long-press qualified (or debounced) level, active low
//   btn_test       out  long-press qualified (or debounced) level, active low
//   gyro           out  debounced level, active low
//   ult            out  debounced level, active high
// -----------------------------------------------------------------------------
module tamagotchi_input_cond #(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_salud_raw,
  input  logic btn_ali_raw,
  input  logic btn_reset_raw,
  input  logic btn_test_raw,
  input  logic gyro_raw,
  input  logic ult_raw,
  output logic btn_salud,
  output logic btn_ali,
  output logic btn_reset,
  output logic btn_test,
  output logic gyro,
  output logic ult
);

  // Bad parameters would leave the prescaler or a counter limit meaningless,
  // so refuse to elaborate instead of building silently wrong hardware.
  if ((CLK_HZ < 1000) || ((CLK_HZ % 1000) != 0) ||
      (DEBOUNCE_MS < 1) || (DEBOUNCE_MS > 255) ||
      (HOLD_MS < 1) || (HOLD_MS > 65535)) begin : g_bad_params
    $error("tamagotchi_input_cond: parameter out of range");
  end

  // Channel order inside every vector below.
  localparam int NCH      = 6;
  localparam int CH_SALUD = 0;
  localparam int CH_ALI   = 1;
  localparam int CH_RESET = 2;
  localparam int CH_TEST  = 3;
  localparam int CH_GYRO  = 4;
  localparam int CH_ULT   = 5;

  // Released level per channel. Everything is active low except ult.
  localparam logic [NCH-1:0] REL_LEVEL = 6'b01_1111;

  localparam int                TICK_DIV   = CLK_HZ / 1000;
  localparam int                PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [7:0]        DB_LIMIT   = 8'(DEBOUNCE_MS);

  logic [NCH-1:0] raw_vec;

  assign raw_vec = {ult_raw, gyro_raw, btn_test_raw, btn_reset_raw,
                    btn_ali_raw, btn_salud_raw};

  // ---------------------------------------------------------------------------
  // 2-flop synchronizers. They reset to the released level, so a reset never
  // looks like a press to the debouncers.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw_vec;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= REL_LEVEL;
      sync2_q <= REL_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared 1 ms prescaler. The tick is decoded from the counter state, so it
  // is high for exactly one cycle out of every TICK_DIV.
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers. The counter is cleared on any cycle where the synchronized
  // input agrees with the stable level, not only on ticks, so a bounce of any
  // length restarts qualification. The count only advances on ticks.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] stable_q, stable_d;
  logic [7:0]     db_cnt_q [NCH];
  logic [7:0]     db_cnt_d [NCH];

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if ((db_cnt_q[i] + 8'd1) == DB_LIMIT) begin
          stable_d[i] = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= REL_LEVEL;
      for (int i = 0; i < NCH; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign btn_salud = stable_q[CH_SALUD];
  assign btn_ali   = stable_q[CH_ALI];
  assign gyro      = stable_q[CH_GYRO];
  assign ult       = stable_q[CH_ULT];

`ifdef INPUT_COND_HOLD_EN
  // ---------------------------------------------------------------------------
  // Long-press qualifiers for btn_reset and btn_test.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ACTIVE
  } hold_state_e;

  typedef struct packed {
    hold_state_e state;
    logic [15:0] cnt;
  } hold_fsm_t;

  localparam logic [15:0] HOLD_LIMIT = 16'(HOLD_MS);
  localparam hold_fsm_t   HOLD_IDLE  = '{state: ST_IDLE, cnt: 16'd0};

  // One step of the press-and-hold machine. Both buttons share it. The caller
  // applies the reset-over-test priority on top of the result.
  function automatic hold_fsm_t hold_next(input hold_fsm_t cur,
                                          input logic      pressed,
                                          input logic      tick_i);
    hold_fsm_t nxt;
    nxt = cur;
    case (cur.state)
      ST_IDLE: begin
        if (pressed) begin
          nxt.state = ST_HOLD;
          nxt.cnt   = '0;
        end
      end
      ST_HOLD: begin
        if (!pressed) begin
          nxt = HOLD_IDLE;
        end else if (tick_i) begin
          if ((cur.cnt + 16'd1) == HOLD_LIMIT) begin
            nxt.state = ST_ACTIVE;
            nxt.cnt   = '0;
          end else begin
            nxt.cnt = cur.cnt + 16'd1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!pressed) begin
          nxt = HOLD_IDLE;
        end
      end
      default: begin
        nxt = HOLD_IDLE;
      end
    endcase
    return nxt;
  endfunction

  hold_fsm_t rst_fsm_q, rst_fsm_d;
  hold_fsm_t tst_fsm_q, tst_fsm_d;

  // The test machine is forced idle whenever reset's next state is ACTIVE.
  // Using the next state makes btn_test release on the same edge that
  // btn_reset asserts. It also means that if both would qualify on the same
  // tick, test never reaches ACTIVE at all.
  always_comb begin
    rst_fsm_d = hold_next(rst_fsm_q, ~stable_q[CH_RESET], tick);
    tst_fsm_d = hold_next(tst_fsm_q, ~stable_q[CH_TEST], tick);
    if (rst_fsm_d.state == ST_ACTIVE) begin
      tst_fsm_d = HOLD_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_fsm_q <= HOLD_IDLE;
      tst_fsm_q <= HOLD_IDLE;
    end else begin
      rst_fsm_q <= rst_fsm_d;
      tst_fsm_q <= tst_fsm_d;
    end
  end

  assign btn_reset = (rst_fsm_q.state != ST_ACTIVE);
  assign btn_test  = (tst_fsm_q.state != ST_ACTIVE) || (rst_fsm_q.state == ST_ACTIVE);
`else
  // Plain debounced levels. A pressed reset still masks test.
  assign btn_reset = stable_q[CH_RESET];
  assign btn_test  = stable_q[CH_TEST] | ~stable_q[CH_RESET];
`endif

endmodule

// File: tb/tb_tamagotchi_input_cond.sv
// -----------------------------------------------------------------------------
// tb_tamagotchi_input_cond
//
// Directed bench for tamagotchi_input_cond with CLK_HZ=4000, DEBOUNCE_MS=3,
// HOLD_MS=10, so one tick occurs every 4 clk. Every scenario starts from a
// fresh reset released on a falling edge. This puts ticks on rising edges
// 4, 8, 12, ... after release, and all expected cycle counts are taken from
// that timeline. Inputs are driven and outputs sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_tamagotchi_input_cond;

  localparam int CLK_HZ      = 4000;
  localparam int DEBOUNCE_MS = 3;
  localparam int HOLD_MS     = 10;

  // Cycles from press to qualified output. Debounce is 3 ticks after the
  // 2-clk synchronizer (12 clk). Hold adds 1 clk for IDLE->HOLD plus 10 ticks.
`ifdef INPUT_COND_HOLD_EN
  localparam int QUAL_CYC   = 52;
  localparam int REL_CYC    = 13;
  localparam int SHORT_LOW  = 0;
  localparam int TEST_AFTER = 0;
`else
  localparam int QUAL_CYC   = 12;
  localparam int REL_CYC    = 12;
  localparam int SHORT_LOW  = 36;
  localparam int TEST_AFTER = 36;
`endif

  localparam int SEL_SALUD = 0;
  localparam int SEL_ALI   = 1;
  localparam int SEL_RESET = 2;
  localparam int SEL_TEST  = 3;
  localparam int SEL_GYRO  = 4;
  localparam int SEL_ULT   = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_salud_raw, btn_ali_raw, btn_reset_raw, btn_test_raw, gyro_raw, ult_raw;
  logic btn_salud, btn_ali, btn_reset, btn_test, gyro, ult;

  int n_checks = 0;
  int n_fail   = 0;

  tamagotchi_input_cond #(
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .HOLD_MS    (HOLD_MS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_salud_raw(btn_salud_raw),
    .btn_ali_raw  (btn_ali_raw),
    .btn_reset_raw(btn_reset_raw),
    .btn_test_raw (btn_test_raw),
    .gyro_raw     (gyro_raw),
    .ult_raw      (ult_raw),
    .btn_salud    (btn_salud),
    .btn_ali      (btn_ali),
    .btn_reset    (btn_reset),
    .btn_test     (btn_test),
    .gyro         (gyro),
    .ult          (ult)
  );

  always #5 clk = ~clk;

  function automatic logic out_sel(input int sel);
    case (sel)
      SEL_SALUD: return btn_salud;
      SEL_ALI:   return btn_ali;
      SEL_RESET: return btn_reset;
      SEL_TEST:  return btn_test;
      SEL_GYRO:  return gyro;
      SEL_ULT:   return ult;
      default:   return 1'bx;
    endcase
  endfunction

  // Release all inputs, pulse reset, and release it on a falling edge.
  task automatic do_reset();
    btn_salud_raw = 1'b1;
    btn_ali_raw   = 1'b1;
    btn_reset_raw = 1'b1;
    btn_test_raw  = 1'b1;
    gyro_raw      = 1'b1;
    ult_raw       = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a selected output to reach a level. Returns the number
  // of falling edges waited, or -1 if the bound ran out.
  task automatic wait_level(input int sel, input logic lvl, input int max_cyc,
                            output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (out_sel(sel) === lvl) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    btn_salud_raw = 1'b1; btn_ali_raw = 1'b1; btn_reset_raw = 1'b1;
    btn_test_raw  = 1'b1; gyro_raw    = 1'b1; ult_raw       = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    got = {btn_salud, btn_ali, btn_reset, btn_test, gyro, ult};
    n_checks++;
    if (got !== 6'b111110) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %b, expected %b", got, 6'b111110);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_salud_debounce();
    int lows;
    int cyc;
    do_reset();
    btn_salud_raw = 1'b0;
    repeat (3) @(negedge clk);
    btn_salud_raw = 1'b1;
    lows = 0;
    for (int k = 4; k <= 20; k++) begin
      @(negedge clk);
      if (btn_salud !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) begin
      n_fail++;
      $display("[TB] FAIL salud_short_press: low cycles %0d, expected 0", lows);
    end
    btn_salud_raw = 1'b0;
    wait_level(SEL_SALUD, 1'b0, 30, cyc);
    n_checks++;
    if (cyc != 12) begin
      n_fail++;
      $display("[TB] FAIL salud_steady_press: fell after %0d clk, expected 12", cyc);
    end
  endtask

  task automatic test_ali_glitch();
    int cyc;
    do_reset();
    btn_ali_raw = 1'b0;
    repeat (8) @(negedge clk);
    btn_ali_raw = 1'b1;
    @(negedge clk);
    btn_ali_raw = 1'b0;
    wait_level(SEL_ALI, 1'b0, 30, cyc);
    n_checks++;
    if (cyc != 11) begin
      n_fail++;
      $display("[TB] FAIL ali_glitch_restart: fell after %0d clk, expected 11", cyc);
    end
  endtask

  task automatic test_gyro_ult();
    int cyc;
    do_reset();
    gyro_raw = 1'b0;
    ult_raw  = 1'b1;
    wait_level(SEL_ULT, 1'b1, 30, cyc);
    n_checks++;
    if (cyc != 12) begin
      n_fail++;
      $display("[TB] FAIL ult_rise: after %0d clk, expected 12", cyc);
    end
    n_checks++;
    if (gyro !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL gyro_fall: got %b, expected 0", gyro);
    end
    gyro_raw = 1'b1;
    ult_raw  = 1'b0;
    wait_level(SEL_GYRO, 1'b1, 30, cyc);
    n_checks++;
    if (cyc != 12) begin
      n_fail++;
      $display("[TB] FAIL gyro_rise: after %0d clk, expected 12", cyc);
    end
    n_checks++;
    if (ult !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ult_fall: got %b, expected 0", ult);
    end
  endtask

  task automatic test_reset_hold();
    int cyc;
    int lows;
    do_reset();
    btn_reset_raw = 1'b0;
    wait_level(SEL_RESET, 1'b0, 100, cyc);
    n_checks++;
    if (cyc != QUAL_CYC) begin
      n_fail++;
      $display("[TB] FAIL reset_long_press: fell after %0d clk, expected %0d", cyc, QUAL_CYC);
    end
    repeat (8) @(negedge clk);
    btn_reset_raw = 1'b1;
    wait_level(SEL_RESET, 1'b1, 40, cyc);
    n_checks++;
    if (cyc != REL_CYC) begin
      n_fail++;
      $display("[TB] FAIL reset_release: rose after %0d clk, expected %0d", cyc, REL_CYC);
    end
    // Short press, released at tick 9.
    do_reset();
    btn_reset_raw = 1'b0;
    lows = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (btn_reset === 1'b0) lows++;
      if (k == 36) btn_reset_raw = 1'b1;
    end
    n_checks++;
    if (lows != SHORT_LOW) begin
      n_fail++;
      $display("[TB] FAIL reset_short_press: low cycles %0d, expected %0d", lows, SHORT_LOW);
    end
  endtask

  task automatic test_reset_priority();
    int   cyc;
    int   lows;
    logic prev_test;
    do_reset();
    btn_test_raw = 1'b0;
    wait_level(SEL_TEST, 1'b0, 100, cyc);
    n_checks++;
    if (cyc != QUAL_CYC) begin
      n_fail++;
      $display("[TB] FAIL test_long_press: fell after %0d clk, expected %0d", cyc, QUAL_CYC);
    end
    btn_reset_raw = 1'b0;
    prev_test = btn_test;
    cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (btn_reset === 1'b0) begin
        cyc = k;
        break;
      end
      prev_test = btn_test;
    end
    n_checks++;
    if (cyc != QUAL_CYC) begin
      n_fail++;
      $display("[TB] FAIL prio_reset_qualify: fell after %0d clk, expected %0d", cyc, QUAL_CYC);
    end
    n_checks++;
    if (prev_test !== 1'b0 || btn_test !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL prio_test_release: before/at %b/%b, expected 0/1", prev_test, btn_test);
    end
    btn_reset_raw = 1'b1;
    wait_level(SEL_RESET, 1'b1, 40, cyc);
    lows = (btn_test === 1'b0) ? 1 : 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (btn_test === 1'b0) lows++;
    end
    n_checks++;
    if (lows != TEST_AFTER) begin
      n_fail++;
      $display("[TB] FAIL prio_test_after_release: low cycles %0d, expected %0d", lows, TEST_AFTER);
    end
  endtask

  task automatic test_reset_midhold();
    int cyc;
    do_reset();
    btn_test_raw = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (btn_test !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midhold_in_reset: btn_test %b, expected 1", btn_test);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_level(SEL_TEST, 1'b0, 100, cyc);
    n_checks++;
    if (cyc != QUAL_CYC) begin
      n_fail++;
      $display("[TB] FAIL midhold_requalify: fell after %0d clk, expected %0d", cyc, QUAL_CYC);
    end
  endtask

  initial begin
    $display("[TB] tamagotchi_input_cond directed test start");
    test_reset();
    test_salud_debounce();
    test_ali_glitch();
    test_gyro_ult();
    test_reset_hold();
    test_reset_priority();
    test_reset_midhold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
